// File: rtl/pm_pkg.sv
// Shared types and defaults for the pattern matching engine.
// Latency: n/a (declarations only); backpressure: n/a.
package pm_pkg;
    localparam int PM_ADDR_W = 9;
    localparam int PM_DATA_W = 8;
    localparam int MEM_DEPTH = 2 ** PM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/pattern_window.sv
// Sliding byte window, saturating fill counter and comparator; hit is combinational on the next-window value.
// Latency: window updates one cycle after shift; no backpressure, shift is accepted every cycle.
module pattern_window
    import pm_pkg::*;
#(
    parameter int DATA_W  = PM_DATA_W,
    parameter int PAT_LEN = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      shift,
    input  logic [DATA_W-1:0]         data,
    input  logic [PAT_LEN*DATA_W-1:0] pat,
    output logic                      hit
);
    localparam int W  = PAT_LEN * DATA_W;
    localparam int CW = $clog2(PAT_LEN + 1);
    localparam logic [CW-1:0] FULL = CW'(PAT_LEN);

    logic [W-1:0]  window;
    logic [W-1:0]  window_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Newest byte enters at the top so byte 0 lines up with pattern byte 0.
    always_comb begin
        window_next = {data, window[W-1:DATA_W]};
        cnt_next    = (cnt == FULL) ? cnt : cnt + 1'b1;
        hit         = shift && (cnt_next == FULL) && (window_next == pat);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            window <= '0;
            cnt    <= '0;
        end else if (clear) begin
            window <= '0;
            cnt    <= '0;
        end else if (shift) begin
            window <= window_next;
            cnt    <= cnt_next;
        end
    end
endmodule

// File: rtl/pattern_compare.sv
// Streams text memory through a sliding window and reports the first pattern match or exhaustion.
// Latency: done 3 cycles after the last matching byte's read address is counted; no backpressure, one read per cycle.
module pattern_compare
    import pm_pkg::*;
#(
    parameter int ADDR_W  = PM_ADDR_W,
    parameter int DATA_W  = PM_DATA_W,
    parameter int PAT_LEN = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inc_flag,
    input  logic [PAT_LEN*DATA_W-1:0] pattern,
    output logic                      mem_rd,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_data,
    output logic                      done_flag,
    output logic                      found,
    output logic [ADDR_W-1:0]         match_address
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] BACK      = ADDR_W'(PAT_LEN - 1);

    state_t                    state;
    logic [ADDR_W-1:0]         addr;
    logic                      issued_last;
    logic                      data_vld;
    logic [ADDR_W-1:0]         data_addr;
    logic [PAT_LEN*DATA_W-1:0] pat_q;
    logic                      start;
    logic                      consume;
    logic                      last_byte;
    logic                      hit;

    assign start     = (state == IDLE) && inc_flag;
    assign consume   = (state == SCAN) && inc_flag && data_vld;
    assign last_byte = (data_addr == LAST_ADDR);

    pattern_window #(
        .DATA_W  (DATA_W),
        .PAT_LEN (PAT_LEN)
    ) u_window (
        .clock (clock),
        .reset (reset),
        .clear (start),
        .shift (consume),
        .data  (mem_data),
        .pat   (pat_q),
        .hit   (hit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            addr          <= '0;
            issued_last   <= 1'b0;
            data_vld      <= 1'b0;
            data_addr     <= '0;
            pat_q         <= '0;
            mem_rd        <= 1'b0;
            mem_addr      <= '0;
            done_flag     <= 1'b0;
            found         <= 1'b0;
            match_address <= '0;
        end else begin
            // Tracks the read in flight; data is only used while scanning.
            data_vld  <= mem_rd;
            data_addr <= mem_addr;
            case (state)
                IDLE: begin
                    mem_rd    <= 1'b0;
                    done_flag <= 1'b0;
                    found     <= 1'b0;
                    if (inc_flag) begin
                        state         <= SCAN;
                        pat_q         <= pattern;
                        addr          <= '0;
                        issued_last   <= 1'b0;
                        match_address <= '0;
                    end
                end
                SCAN: begin
                    if (!inc_flag) begin
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                    end else if (consume && (hit || last_byte)) begin
                        // A match on the final byte outranks exhaustion.
                        state         <= DONE;
                        mem_rd        <= 1'b0;
                        done_flag     <= 1'b1;
                        found         <= hit;
                        match_address <= hit ? (data_addr - BACK) : '0;
                    end else if (!issued_last) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= addr;
                        if (addr == LAST_ADDR) begin
                            issued_last <= 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end else begin
                        mem_rd <= 1'b0;
                    end
                end
                DONE: begin
                    mem_rd <= 1'b0;
                    if (!inc_flag) begin
                        state     <= IDLE;
                        done_flag <= 1'b0;
                        found     <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_compare.sv
// Randomised bench for pattern_compare with a search-by-definition reference model.
module tb_pattern_compare;
    import pm_pkg::*;

    localparam int PL  = 4;
    localparam int MEM = 512;

    logic        clock = 1'b0;
    logic        reset;
    logic        inc_flag;
    logic [31:0] pattern;
    logic        mem_rd;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        done_flag;
    logic        found;
    logic [8:0]  match_address;

    logic [7:0]  mem [MEM];

    int total = 0;
    int bad   = 0;
    int cyc;
    int done_cyc;
    int exp_addr;
    int drop_cyc;
    int first_done;
    int last_addr;
    bit on;
    bit exp_found;

    pattern_compare #(
        .ADDR_W  (9),
        .DATA_W  (8),
        .PAT_LEN (PL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .inc_flag      (inc_flag),
        .pattern       (pattern),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .done_flag     (done_flag),
        .found         (found),
        .match_address (match_address)
    );

    always #5 clock = ~clock;

    // Synchronous text memory: data one cycle after the strobe.
    always @(posedge clock) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Lowest address where all pattern bytes appear consecutively, or -1.
    function automatic int find_first(input logic [31:0] pat);
        for (int f = 0; f <= MEM - PL; f++) begin
            bit ok = 1'b1;
            for (int i = 0; i < PL; i++)
                if (mem[f + i] != pat[8*i +: 8]) ok = 1'b0;
            if (ok) return f;
        end
        return -1;
    endfunction

    task automatic compare();
        bit after, e_done, e_rd, keep;
        after  = cyc > drop_cyc;
        e_done = !after && (cyc >= done_cyc);
        e_rd   = !after && (cyc >= 1) && (cyc <= MEM) && (cyc < done_cyc);
        keep   = after ? (drop_cyc >= done_cyc) : e_done;
        chk("mem_rd", 32'(mem_rd), 32'(e_rd));
        if (e_rd) chk("mem_addr", 32'(mem_addr), cyc - 1);
        chk("done_flag", 32'(done_flag), 32'(e_done));
        chk("found", 32'(found), 32'(e_done && exp_found));
        chk("match_address", 32'(match_address), keep ? exp_addr : 0);
        if (done_flag === 1'b1 && first_done < 0) first_done = cyc;
        if (mem_rd === 1'b1) last_addr = int'(mem_addr);
    endtask

    task automatic tick();
        @(negedge clock);
        if (on) compare();
        #1;
        cyc++;
    endtask

    task automatic fill(input int maxv);
        for (int i = 0; i < MEM; i++) mem[i] = 8'($urandom_range(0, maxv));
    endtask

    task automatic place(input int a, input logic [31:0] pat);
        for (int i = 0; i < PL; i++) mem[a + i] = pat[8*i +: 8];
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_done"}, 32'(done_flag), 0);
        chk({tag, "_found"}, 32'(found), 0);
        chk({tag, "_match"}, 32'(match_address), 0);
    endtask

    // Called mid-cycle; the next rising edge is cycle 0 of the search.
    task automatic search(input logic [31:0] pat, input int drop_at, input int rst_at);
        int f;
        f          = find_first(pat);
        exp_found  = (f >= 0);
        exp_addr   = (f >= 0) ? f : 0;
        done_cyc   = (f >= 0) ? f + PL + 2 : MEM + 2;
        pattern    = pat;
        inc_flag   = 1'b1;
        cyc        = 0;
        drop_cyc   = 1 << 30;
        first_done = -1;
        last_addr  = -1;
        on         = 1'b1;
        tick();
        pattern = ~pat;
        if (rst_at >= 0) begin
            while (cyc <= rst_at) tick();
            on       = 1'b0;
            inc_flag = 1'b0;
            reset    = 1'b0;
            #1;
            chk_all_zero("async_rst");
            @(negedge clock);
            #1;
            reset = 1'b1;
            repeat (4) begin
                @(negedge clock);
                chk("post_rst_mem_rd", 32'(mem_rd), 0);
                chk("post_rst_done", 32'(done_flag), 0);
                #1;
            end
        end else begin
            while (cyc <= drop_at) tick();
            inc_flag = 1'b0;
            drop_cyc = drop_at;
            tick();
            on = 1'b0;
        end
    endtask

    initial begin
        int f, dc, k;
        logic [31:0] p;
        reset    = 1'b0;
        inc_flag = 1'b0;
        pattern  = '0;
        on       = 1'b0;
        cyc      = 0;
        drop_cyc = 0;
        done_cyc = 0;
        for (int i = 0; i < MEM; i++) mem[i] = '0;
        #2;
        chk_all_zero("reset");
        @(negedge clock);
        #1;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("idle_mem_rd", 32'(mem_rd), 0);
            chk("idle_done", 32'(done_flag), 0);
            #1;
        end

        fill(127);
        place('h010, 32'hDEADBEEF);
        search(32'hDEADBEEF, 24, -1);
        chk("deadbeef_done_cycle", first_done, 22);
        chk("deadbeef_addr", 32'(match_address), 'h010);

        fill(127);
        search(32'hFFFFFFFF, 516, -1);
        chk("nomatch_done_cycle", first_done, 514);
        chk("nomatch_last_addr", last_addr, 'h1FF);

        fill(127);
        place('h1FC, 32'h89ABCDEF);
        search(32'h89ABCDEF, 515, -1);
        chk("tail_done_cycle", first_done, 514);
        chk("tail_addr", 32'(match_address), 'h1FC);

        for (int i = 0; i < MEM; i++) mem[i] = 8'h55;
        for (int i = 0; i < 5; i++) mem['h020 + i] = 8'hAA;
        search(32'hAAAAAAAA, 40, -1);
        chk("overlap_done_cycle", first_done, 38);
        chk("overlap_addr", 32'(match_address), 'h020);

        fill(127);
        place('h030, 32'h11223344);
        search(32'hFFFFFFFF, 10, -1);
        chk("abort_no_done", first_done, -1);
        search(32'h11223344, 56, -1);
        chk("restart_done_cycle", first_done, 54);

        search(32'h11223344, 0, 20);
        search(32'h11223344, 0, 56);
        search(32'h11223344, 56, -1);
        chk("after_reset_done_cycle", first_done, 54);

        for (int n = 0; n < 8; n++) begin
            k = $urandom_range(1, 3);
            fill(k);
            for (int i = 0; i < PL; i++) p[8*i +: 8] = 8'($urandom_range(0, k));
            f  = find_first(p);
            dc = (f >= 0) ? f + PL + 2 : MEM + 2;
            search(p, dc + $urandom_range(0, 3), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pattern_compare.md
# pattern_compare

Compare stage of the pattern matching engine. It sits directly upstream of the search FSM, which raises `inc_flag` to request a search. While enabled, this block streams the 512-entry text memory through a sliding window and compares it against a PAT_LEN-byte pattern. It reports `done_flag`, `found` and `match_address`; the FSM consumes `done_flag` and `match_address`.

## Interface
- ADDR_W, 9, text memory address width; also the width of `match_address`
- DATA_W, 8, memory word / pattern byte width
- PAT_LEN, 4, pattern length in bytes; legal range 2..8
- clock  in  1  single rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- inc_flag  in  1  search enable from FSM; level-sensitive
- pattern  in  PAT_LEN*DATA_W  pattern; byte 0 = bits [DATA_W-1:0] = first byte in memory order
- mem_rd  out  1  read strobe
- mem_addr  out  ADDR_W  read address
- mem_data  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd`
- done_flag  out  1  search finished; held until `inc_flag` falls
- found  out  1  qualifies `done_flag`: 1 = match, 0 = memory exhausted
- match_address  out  ADDR_W  address of the first byte of the match; 0 when `found`=0

## Operation
- States: IDLE, SCAN, DONE.
- Reset: state=IDLE. All outputs, the address counter, the byte counter and the window are 0.
- IDLE:
  - `mem_rd`=0, `done_flag`=0.
  - `inc_flag`=1 at an edge: go to SCAN, load `pattern` into `pat_q`, clear the address counter, byte counter and window.
- SCAN:
  - Each cycle: `mem_rd`=1, `mem_addr`=addr, then addr increments.
  - Addr saturates at 2^ADDR_W-1. No wrap; no read is issued past the last address.
  - A returned byte shifts into the window at the top: window = {mem_data, window[top:DATA_W]}. Byte 0 of the window is the oldest byte.
  - The comparison uses the next-window value, i.e. it includes the arriving byte.
  - Match condition: ≥PAT_LEN bytes received (counting the arriving byte) and window_next == `pat_q`.
  - On match: go to DONE; `done_flag`=1, `found`=1, `match_address` = address of the arriving byte − (PAT_LEN−1).
  - On exhaustion (the byte from address 2^ADDR_W−1 arrives without a match): go to DONE; `done_flag`=1, `found`=0, `match_address`=0.
  - If match and exhaustion occur on the same byte, the match wins.
  - `inc_flag`=0 during SCAN: go to IDLE at the next edge. The outstanding read is discarded, `done_flag` is never raised, and outputs are unchanged.
- DONE:
  - `mem_rd`=0. `done_flag`, `found` and `match_address` are held.
  - Read data returning from a read speculatively issued before the match is ignored.
  - `inc_flag`=0: go to IDLE and clear `done_flag` and `found`. `match_address` is held until the next search starts.
- `pattern` changes during SCAN or DONE are ignored.
- Only the first (lowest-address) match is reported. Overlapping occurrences are detected because the window slides by one byte.

## Timing
- Cycle 0 = the edge at which IDLE samples `inc_flag`=1.
- Read of address A is issued in cycle A+1. Its data arrives in cycle A+2.
- Match whose last byte is at address L: `done_flag`=1 from cycle L+3. With first byte F: from cycle F+PAT_LEN+2.
- Earliest possible `done_flag`: cycle PAT_LEN+2, for a match at address 0.
- No match: the last read is issued in cycle 2^ADDR_W. `done_flag`=1 from cycle 2^ADDR_W+2 (514 for defaults).
- `done_flag` falls 1 cycle after `inc_flag` falls.
- IDLE→SCAN restart is possible on the edge after the IDLE entry.
- Reset asserted in any state: IDLE immediately and all outputs 0, regardless of the clock.

## Structure
- Shared package `pm_pkg`:
  - state enum {IDLE, SCAN, DONE}
  - ADDR_W/DATA_W defaults
  - MEM_DEPTH = 2**ADDR_W
- Sub-module `pattern_window`: PAT_LEN×DATA_W shift register, byte counter (saturating at PAT_LEN) and equality comparator.
  - Its output is the combinational `hit` on window_next.
  - The top level holds the FSM, the address counter and the pipeline address register used to compute `match_address`.

## Test plan
- Pattern 0xDEADBEEF bytes placed at 0x010..0x013, `inc_flag`=1 → `done_flag` rises in cycle 22; `found`=1; `match_address`=0x010; `mem_rd` low from then on.
- Memory with no occurrence → `done_flag`, `found`=0 and `match_address`=0 in cycle 514. The last `mem_addr` is 0x1FF with no wrap to 0.
- Match at the final 4 bytes (0x1FC..0x1FF) → `found`=1, `match_address`=0x1FC, `done_flag` in cycle 514; this covers match and exhaustion on the same byte.
- Overlap: memory 0xAA×5 at 0x020, pattern 0xAAAAAAAA → `match_address`=0x020.
- `inc_flag` dropped in cycle 10 of a scan → IDLE in cycle 11 with no `done_flag`. A restart then rescans from address 0 with the new pattern.
- `reset` pulsed low mid-SCAN and also in DONE → all outputs 0 asynchronously; after release the block stays in IDLE until `inc_flag` is sampled high.
